// File: rtl/cache_ctrl_2way_if.sv
// Bundle of CPU, backing-memory and tag/data-array signals around the 2-way cache controller.
// Latency: none (wires only).
// Backpressure: cpu_ready and mem_ack carry all flow control; the arrays never stall.
interface cache_ctrl_2way_if #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int LINE_W = 64,
  parameter int TAG_W  = 15
);
  logic              cpu_req_valid;
  logic              cpu_req_rw;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [WORD_W-1:0] cpu_req_wdata;
  logic              cpu_ready;
  logic              cpu_resp_valid;
  logic [WORD_W-1:0] cpu_resp_rdata;

  logic              mem_req_valid;
  logic              mem_req_rw;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [LINE_W-1:0] mem_req_wdata;
  logic              mem_ack;
  logic [LINE_W-1:0] mem_rdata;

  logic              arr_index;
  logic              arr_we;
  logic [TAG_W-1:0]  arr_tag_w1;
  logic [TAG_W-1:0]  arr_tag_w2;
  logic [LINE_W-1:0] arr_data_w1;
  logic [LINE_W-1:0] arr_data_w2;
  logic [TAG_W-1:0]  arr_tag_r1;
  logic [TAG_W-1:0]  arr_tag_r2;
  logic [LINE_W-1:0] arr_data_r1;
  logic [LINE_W-1:0] arr_data_r2;

  // Controller side
  modport master (
    input  cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_wdata,
    output cpu_ready, cpu_resp_valid, cpu_resp_rdata,
    output mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
    input  mem_ack, mem_rdata,
    output arr_index, arr_we, arr_tag_w1, arr_tag_w2, arr_data_w1, arr_data_w2,
    input  arr_tag_r1, arr_tag_r2, arr_data_r1, arr_data_r2
  );

  // CPU / memory / array side
  modport slave (
    output cpu_req_valid, cpu_req_rw, cpu_req_addr, cpu_req_wdata,
    input  cpu_ready, cpu_resp_valid, cpu_resp_rdata,
    input  mem_req_valid, mem_req_rw, mem_req_addr, mem_req_wdata,
    output mem_ack, mem_rdata,
    input  arr_index, arr_we, arr_tag_w1, arr_tag_w2, arr_data_w1, arr_data_w2,
    output arr_tag_r1, arr_tag_r2, arr_data_r1, arr_data_r2
  );
endinterface

// File: rtl/cache_ctrl_2way.sv
// Controller for a 2-way, 2-set cache: lookup, LRU victim choice, dirty write-back, refill.
// Latency: hit response 1 cycle after acceptance; a miss adds write-back/refill memory round trips.
// Backpressure: cpu_ready only in IDLE; memory requests held until mem_ack. Optional stats: CACHE_STATS_EN.
module cache_ctrl_2way #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 16,
  parameter int LINE_W = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  cache_ctrl_2way_if.master     bus
`ifdef CACHE_STATS_EN
  ,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
`endif
);

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [ADDR_W-4:0] tag;
  } tag_ent_t;

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, ALLOCATE} state_t;

  state_t            state;
  logic [1:0]        lru;          // per set: 0 -> way1 is next victim, 1 -> way2
  logic              req_rw;
  logic [ADDR_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              victim;       // 0 = way1, 1 = way2
  logic              mem_req_valid_q;
  logic              mem_req_rw_q;
  logic [ADDR_W-1:0] mem_req_addr_q;
  logic [LINE_W-1:0] mem_req_wdata_q;

  logic              idx;
  logic [ADDR_W-4:0] req_tag;
  tag_ent_t          t1, t2, v_ent;
  logic              hit1, hit2, hit, miss_victim;
  logic [LINE_W-1:0] hit_line, merged_line, v_line;
  logic [WORD_W-1:0] hit_word;
  logic              ack_fill, ack_wb;

  assign idx      = req_addr[2];
  assign req_tag  = req_addr[ADDR_W-1:3];
  assign t1       = bus.arr_tag_r1;
  assign t2       = bus.arr_tag_r2;
  // Way1 wins if both ways claim the tag
  assign hit1     = t1.valid && (t1.tag == req_tag);
  assign hit2     = !hit1 && t2.valid && (t2.tag == req_tag);
  assign hit      = hit1 || hit2;
  assign hit_line = hit1 ? bus.arr_data_r1 : bus.arr_data_r2;
  assign hit_word = hit_line[int'(req_addr[1:0])*WORD_W +: WORD_W];

  // Invalid ways are filled first (way1 priority), otherwise the LRU way is evicted
  assign miss_victim = !t1.valid ? 1'b0 : (!t2.valid ? 1'b1 : lru[idx]);
  assign v_ent       = miss_victim ? t2 : t1;
  assign v_line      = miss_victim ? bus.arr_data_r2 : bus.arr_data_r1;

  assign ack_wb   = (state == WRITEBACK) && mem_req_valid_q && bus.mem_ack;
  assign ack_fill = (state == ALLOCATE) && mem_req_valid_q && bus.mem_ack;

  // Store merge: replace the addressed word of the hit line
  always_comb begin
    merged_line = hit_line;
    merged_line[int'(req_addr[1:0])*WORD_W +: WORD_W] = req_wdata;
  end

  // Response and array writes are combinational so a hit completes in the COMPARE cycle;
  // the memory request side is fully registered.
  always_comb begin
    bus.cpu_ready      = (state == IDLE);
    bus.cpu_resp_valid = (state == COMPARE) && hit;
    bus.cpu_resp_rdata = bus.cpu_resp_valid ? hit_word : '0;
    bus.arr_index      = idx;
    bus.arr_we         = 1'b0;
    bus.arr_tag_w1     = '0;
    bus.arr_tag_w2     = '0;
    bus.arr_data_w1    = '0;
    bus.arr_data_w2    = '0;
    if ((state == COMPARE) && hit && req_rw) begin
      bus.arr_we      = 1'b1;
      bus.arr_tag_w1  = bus.arr_tag_r1;
      bus.arr_tag_w2  = bus.arr_tag_r2;
      bus.arr_data_w1 = bus.arr_data_r1;
      bus.arr_data_w2 = bus.arr_data_r2;
      if (hit1) begin
        bus.arr_tag_w1  = {1'b1, 1'b1, req_tag};
        bus.arr_data_w1 = merged_line;
      end else begin
        bus.arr_tag_w2  = {1'b1, 1'b1, req_tag};
        bus.arr_data_w2 = merged_line;
      end
    end else if (ack_fill) begin
      bus.arr_we      = 1'b1;
      bus.arr_tag_w1  = bus.arr_tag_r1;
      bus.arr_tag_w2  = bus.arr_tag_r2;
      bus.arr_data_w1 = bus.arr_data_r1;
      bus.arr_data_w2 = bus.arr_data_r2;
      if (!victim) begin
        bus.arr_tag_w1  = {1'b1, 1'b0, req_tag};
        bus.arr_data_w1 = bus.mem_rdata;
      end else begin
        bus.arr_tag_w2  = {1'b1, 1'b0, req_tag};
        bus.arr_data_w2 = bus.mem_rdata;
      end
    end
  end

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_rw    = mem_req_rw_q;
  assign bus.mem_req_addr  = mem_req_addr_q;
  assign bus.mem_req_wdata = mem_req_wdata_q;

  // Main FSM: request latch, LRU update, victim capture and memory request sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      lru             <= '0;
      req_rw          <= 1'b0;
      req_addr        <= '0;
      req_wdata       <= '0;
      victim          <= 1'b0;
      mem_req_valid_q <= 1'b0;
      mem_req_rw_q    <= 1'b0;
      mem_req_addr_q  <= '0;
      mem_req_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            req_rw    <= bus.cpu_req_rw;
            req_addr  <= bus.cpu_req_addr;
            req_wdata <= bus.cpu_req_wdata;
            state     <= COMPARE;
          end
        end
        COMPARE: begin
          if (hit) begin
            lru[idx] <= hit1;
            state    <= IDLE;
          end else begin
            victim          <= miss_victim;
            mem_req_valid_q <= 1'b1;
            if (v_ent.valid && v_ent.dirty) begin
              mem_req_rw_q    <= 1'b1;
              mem_req_addr_q  <= {v_ent.tag, idx, 2'b00};
              mem_req_wdata_q <= v_line;
              state           <= WRITEBACK;
            end else begin
              mem_req_rw_q    <= 1'b0;
              mem_req_addr_q  <= {req_tag, idx, 2'b00};
              state           <= ALLOCATE;
            end
          end
        end
        WRITEBACK: begin
          if (ack_wb) begin
            mem_req_valid_q <= 1'b0;
            state           <= ALLOCATE;
          end
        end
        ALLOCATE: begin
          // After a write-back the request drops for one cycle before the refill is issued
          if (!mem_req_valid_q) begin
            mem_req_valid_q <= 1'b1;
            mem_req_rw_q    <= 1'b0;
            mem_req_addr_q  <= {req_tag, idx, 2'b00};
          end else if (bus.mem_ack) begin
            mem_req_valid_q <= 1'b0;
            state           <= COMPARE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic relookup;

  // Saturating hit/miss counters over first-pass lookups; the post-refill re-lookup is skipped
  always_ff @(posedge clk) begin
    if (reset) begin
      relookup   <= 1'b0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (ack_fill) begin
        relookup <= 1'b1;
      end else if (state == COMPARE) begin
        relookup <= 1'b0;
      end
      if ((state == COMPARE) && !relookup) begin
        if (hit && (hit_count != 16'hFFFF)) begin
          hit_count <= hit_count + 16'd1;
        end
        if (!hit && (miss_count != 16'hFFFF)) begin
          miss_count <= miss_count + 16'd1;
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_cache_ctrl_2way.sv
// Directed bench for cache_ctrl_2way with a behavioural 2x2 tag/data array.
// Latency: checks hit responses one cycle after acceptance and the write-back/refill ordering.
// Backpressure: memory acks driven by hand; every wait on the DUT is cycle-bounded.
module tb_cache_ctrl_2way;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  cache_ctrl_2way_if bus ();

`ifdef CACHE_STATS_EN
  logic [15:0] hit_count, miss_count;
`endif

  cache_ctrl_2way dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Behavioural arrays: combinational read, write of both ways on arr_we, cleared by reset
  logic [14:0] tag_arr  [2][2];
  logic [63:0] data_arr [2][2];

  always @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < 2; s++) begin
        for (int w = 0; w < 2; w++) begin
          tag_arr[s][w]  <= '0;
          data_arr[s][w] <= '0;
        end
      end
    end else if (bus.arr_we) begin
      tag_arr[bus.arr_index][0]  <= bus.arr_tag_w1;
      tag_arr[bus.arr_index][1]  <= bus.arr_tag_w2;
      data_arr[bus.arr_index][0] <= bus.arr_data_w1;
      data_arr[bus.arr_index][1] <= bus.arr_data_w2;
    end
  end

  assign bus.arr_tag_r1  = tag_arr[bus.arr_index][0];
  assign bus.arr_tag_r2  = tag_arr[bus.arr_index][1];
  assign bus.arr_data_r1 = data_arr[bus.arr_index][0];
  assign bus.arr_data_r2 = data_arr[bus.arr_index][1];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic req(input logic rw, input logic [15:0] addr, input logic [15:0] wdata);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_rw    = rw;
    bus.cpu_req_addr  = addr;
    bus.cpu_req_wdata = wdata;
  endtask

  // Step to the cycle after acceptance and withdraw the request
  task automatic accept_step();
    @(negedge clk);
    bus.cpu_req_valid = 1'b0;
  endtask

  // Bounded wait for a memory request, sampled on negedges
  task automatic wait_mem(input string tag);
    int n = 0;
    while (!bus.mem_req_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " req_valid"}, 64'(bus.mem_req_valid), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    reset             = 1'b1;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_rw    = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wdata = '0;
    bus.mem_ack       = 1'b0;
    bus.mem_rdata     = '0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst cpu_ready", 64'(bus.cpu_ready), 64'd1);
    chk("rst resp_valid", 64'(bus.cpu_resp_valid), 64'd0);
    chk("rst mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("rst arr_we", 64'(bus.arr_we), 64'd0);
    chk("rst mem_req_addr", 64'(bus.mem_req_addr), 64'd0);
`ifdef CACHE_STATS_EN
    chk("rst hit_count", 64'(hit_count), 64'd0);
    chk("rst miss_count", 64'(miss_count), 64'd0);
`endif
    reset = 1'b0;
    @(negedge clk);

    // 1: read miss on 0x0010, refill, re-lookup returns word0
    req(1'b0, 16'h0010, 16'h0);
    accept_step();
    chk("t1 miss no resp", 64'(bus.cpu_resp_valid), 64'd0);
    chk("t1 busy", 64'(bus.cpu_ready), 64'd0);
    wait_mem("t1 alloc");
    chk("t1 alloc rw", 64'(bus.mem_req_rw), 64'd0);
    chk("t1 alloc addr", 64'(bus.mem_req_addr), 64'h0010);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h4444_3333_2222_1111;
    #1;
    chk("t1 fill we", 64'(bus.arr_we), 64'd1);
    chk("t1 fill tag1", 64'(bus.arr_tag_w1), 64'h4002);
    chk("t1 fill data1", bus.arr_data_w1, 64'h4444_3333_2222_1111);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("t1 resp", 64'(bus.cpu_resp_valid), 64'd1);
    chk("t1 rdata", 64'(bus.cpu_resp_rdata), 64'h1111);
    chk("t1 req dropped", 64'(bus.mem_req_valid), 64'd0);
    @(negedge clk);
    chk("t1 idle", 64'(bus.cpu_ready), 64'd1);

    // 2: read hit on 0x0012, response the cycle after acceptance
    req(1'b0, 16'h0012, 16'h0);
    accept_step();
    chk("t2 resp", 64'(bus.cpu_resp_valid), 64'd1);
    chk("t2 rdata", 64'(bus.cpu_resp_rdata), 64'h3333);
    chk("t2 no mem", 64'(bus.mem_req_valid), 64'd0);
    chk("t2 no we", 64'(bus.arr_we), 64'd0);
    @(negedge clk);
    chk("t2 idle", 64'(bus.cpu_ready), 64'd1);
    chk("t2 no mem after", 64'(bus.mem_req_valid), 64'd0);

    // 3: write hit on 0x0011, then read it back
    req(1'b1, 16'h0011, 16'hBEEF);
    accept_step();
    chk("t3 we", 64'(bus.arr_we), 64'd1);
    chk("t3 tag1 dirty", 64'(bus.arr_tag_w1), 64'h6002);
    chk("t3 data1 merged", bus.arr_data_w1, 64'h4444_3333_BEEF_1111);
    chk("t3 tag2 passthru", 64'(bus.arr_tag_w2), 64'h0);
    chk("t3 resp", 64'(bus.cpu_resp_valid), 64'd1);
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("t6 hit_count", 64'(hit_count), 64'd2);
    chk("t6 miss_count", 64'(miss_count), 64'd1);
`endif
    req(1'b0, 16'h0011, 16'h0);
    accept_step();
    chk("t3 readback resp", 64'(bus.cpu_resp_valid), 64'd1);
    chk("t3 readback rdata", 64'(bus.cpu_resp_rdata), 64'hBEEF);
    @(negedge clk);
`ifdef CACHE_STATS_EN
    chk("t6 hit_count after readback", 64'(hit_count), 64'd3);
`endif

    // 4a: fill way2 of set0 with tag 0x004 (clean victim, straight to refill)
    req(1'b0, 16'h0020, 16'h0);
    accept_step();
    wait_mem("t4 fill2");
    chk("t4 fill2 rw", 64'(bus.mem_req_rw), 64'd0);
    chk("t4 fill2 addr", 64'(bus.mem_req_addr), 64'h0020);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h8888_7777_6666_5555;
    #1;
    chk("t4 fill2 tag2", 64'(bus.arr_tag_w2), 64'h4004);
    chk("t4 fill2 tag1 passthru", 64'(bus.arr_tag_w1), 64'h6002);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("t4 fill2 rdata", 64'(bus.cpu_resp_rdata), 64'h5555);
    @(negedge clk);

    // 4b: read 0x0040 evicts dirty LRU way1: write-back first, then refill
    req(1'b0, 16'h0040, 16'h0);
    accept_step();
    wait_mem("t4 wb");
    chk("t4 wb rw", 64'(bus.mem_req_rw), 64'd1);
    chk("t4 wb addr", 64'(bus.mem_req_addr), 64'h0010);
    chk("t4 wb wdata", bus.mem_req_wdata, 64'h4444_3333_BEEF_1111);
    @(negedge clk);
    chk("t4 wb held valid", 64'(bus.mem_req_valid), 64'd1);
    chk("t4 wb held addr", 64'(bus.mem_req_addr), 64'h0010);
    chk("t4 wb held wdata", bus.mem_req_wdata, 64'h4444_3333_BEEF_1111);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("t4 wb dropped", 64'(bus.mem_req_valid), 64'd0);
    wait_mem("t4 alloc");
    chk("t4 alloc rw", 64'(bus.mem_req_rw), 64'd0);
    chk("t4 alloc addr", 64'(bus.mem_req_addr), 64'h0040);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'hDDDD_CCCC_BBBB_AAAA;
    #1;
    chk("t4 alloc tag1", 64'(bus.arr_tag_w1), 64'h4008);
    chk("t4 alloc data1", bus.arr_data_w1, 64'hDDDD_CCCC_BBBB_AAAA);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("t4 alloc resp", 64'(bus.cpu_resp_valid), 64'd1);
    chk("t4 alloc rdata", 64'(bus.cpu_resp_rdata), 64'hAAAA);
    @(negedge clk);

    // 5: dirty way1, touch way2, then miss to force a write-back and reset during it
    req(1'b1, 16'h0040, 16'h1234);
    accept_step();
    chk("t5 write hit", 64'(bus.cpu_resp_valid), 64'd1);
    @(negedge clk);
    req(1'b0, 16'h0020, 16'h0);
    accept_step();
    chk("t5 way2 rdata", 64'(bus.cpu_resp_rdata), 64'h5555);
    @(negedge clk);
    req(1'b0, 16'h0080, 16'h0);
    accept_step();
    wait_mem("t5 wb");
    chk("t5 wb rw", 64'(bus.mem_req_rw), 64'd1);
    chk("t5 wb addr", 64'(bus.mem_req_addr), 64'h0040);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5 rst cpu_ready", 64'(bus.cpu_ready), 64'd1);
    chk("t5 rst mem_req_valid", 64'(bus.mem_req_valid), 64'd0);
    chk("t5 rst resp", 64'(bus.cpu_resp_valid), 64'd0);
`ifdef CACHE_STATS_EN
    chk("t5 rst hit_count", 64'(hit_count), 64'd0);
    chk("t5 rst miss_count", 64'(miss_count), 64'd0);
`endif
    reset = 1'b0;

    // Stray ack in IDLE is ignored
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("stray ack idle", 64'(bus.cpu_ready), 64'd1);
    chk("stray ack no req", 64'(bus.mem_req_valid), 64'd0);

    // Recovery after reset: fresh miss goes through refill
    req(1'b0, 16'h0014, 16'h0);
    accept_step();
    wait_mem("post rst");
    chk("post rst addr", 64'(bus.mem_req_addr), 64'h0014);
    chk("post rst index", 64'(bus.arr_index), 64'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    chk("post rst rdata", 64'(bus.cpu_resp_rdata), 64'hCDEF);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
